// File: rtl/onedconv_row_sequencer_if.sv
// Handshake/status bundle between the row sequencer and its controller.
// The sequencer sits on the slave side; the feeder/controller drives the master side.
interface onedconv_row_sequencer_if #(
    parameter int CNT_W = 16
);
    // controller -> sequencer
    logic             en;
    logic             start;
    logic             stall;
    logic             abort;
    // sequencer -> controller / datapath
    logic             next_row_clr_n;
    logic             set_en;
    logic             o_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] col_idx;
    logic [CNT_W-1:0] row_idx;

    modport master (
        output en, start, stall, abort,
        input  next_row_clr_n, set_en, o_en, busy, done, col_idx, row_idx
    );

    modport slave (
        input  en, start, stall, abort,
        output next_row_clr_n, set_en, o_en, busy, done, col_idx, row_idx
    );
endinterface

// File: rtl/onedconv_row_sequencer.sv
// Row sequencer for the 1-D convolution datapath.
// Walks NUM_ROWS rows of ROW_LEN pixels through a KERNEL-tap shift register:
// FILL loads the first KERNEL-1 taps, RUN produces one result per accepted pixel,
// ROW_END clears the row buffer for one cycle between rows, DONE pulses once.
// set_en/o_en depend combinationally on stall; everything else decodes state_q.
module onedconv_row_sequencer #(
    parameter int ROW_LEN  = 28,
    parameter int NUM_ROWS = 28,
    parameter int KERNEL   = 3,
    parameter int CNT_W    = 16
) (
    input  logic                      ONEDCONV_STATEMACHINE_Clk,
    input  logic                      ONEDCONV_STATEMACHINE_Reset,
    onedconv_row_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_FILL    = 3'd2,
        S_RUN     = 3'd3,
        S_ROW_END = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Column at which the last fill pixel is accepted (unused when KERNEL==1).
    localparam int               FILL_LAST_I = (KERNEL > 1) ? (KERNEL - 2) : 0;
    localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(FILL_LAST_I);
    localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(ROW_LEN - 1);
    localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(NUM_ROWS - 1);
    // A single-tap kernel has nothing to pre-load, so rows start straight in RUN.
    localparam state_t           ROW_START   = (KERNEL > 1) ? S_FILL : S_RUN;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;

    logic             pix_active;
    logic             acc;
    logic             clr_n;
    logic             set_en;
    logic             o_en;
    logic             busy;
    logic             done;

    // A pixel is taken only while loading or running and the feeder has one ready.
    always_comb begin
        pix_active = (state_q == S_FILL) || (state_q == S_RUN);
        acc        = pix_active && !bus.stall;
    end

    // Next-state, counter update and output decode.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        clr_n   = 1'b0;
        set_en  = 1'b0;
        o_en    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Row buffer held in clear while idle.
                if (bus.en) begin
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                clr_n = 1'b1;
                if (bus.start) begin
                    state_d = ROW_START;
                    col_d   = '0;
                    row_d   = '0;
                end
            end

            S_FILL: begin
                clr_n  = 1'b1;
                busy   = 1'b1;
                set_en = acc;
                if (acc) begin
                    col_d = col_q + CNT_W'(1);
                    // Leaves col == KERNEL-1 on entry to RUN.
                    if (col_q == FILL_LAST) begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                clr_n  = 1'b1;
                busy   = 1'b1;
                set_en = acc;
                o_en   = acc;
                if (acc) begin
                    col_d = col_q + CNT_W'(1);
                    if (col_q == COL_LAST) begin
                        state_d = (row_q == ROW_LAST) ? S_DONE : S_ROW_END;
                    end
                end
            end

            S_ROW_END: begin
                // One-cycle buffer clear between rows; stall has no effect here.
                busy    = 1'b1;
                row_d   = row_q + CNT_W'(1);
                col_d   = '0;
                state_d = ROW_START;
            end

            S_DONE: begin
                // Counters keep their final values until the next start.
                clr_n   = 1'b1;
                done    = 1'b1;
                state_d = bus.en ? S_ARMED : S_IDLE;
            end

            default: begin
                // Unreachable encodings fall back to a clean idle.
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        endcase

        // Abort wins over start and stall; no done pulse is produced.
        if (bus.abort) begin
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
        end
    end

    // State and position registers; reset returns straight to idle, no resume.
    always_ff @(posedge ONEDCONV_STATEMACHINE_Clk or negedge ONEDCONV_STATEMACHINE_Reset) begin
        if (!ONEDCONV_STATEMACHINE_Reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Drive the bundle.
    always_comb begin
        bus.next_row_clr_n = clr_n;
        bus.set_en         = set_en;
        bus.o_en           = o_en;
        bus.busy           = busy;
        bus.done           = done;
        bus.col_idx        = col_q;
        bus.row_idx        = row_q;
    end

endmodule

// File: tb/tb_onedconv_row_sequencer.sv
// Directed bench for the 1-D convolution row sequencer.
// dut_a: ROW_LEN=8 NUM_ROWS=2 KERNEL=3; dut_b: ROW_LEN=4 NUM_ROWS=3 KERNEL=1.
module tb_onedconv_row_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    onedconv_row_sequencer_if #(.CNT_W(16)) ifa ();
    onedconv_row_sequencer_if #(.CNT_W(16)) ifb ();

    onedconv_row_sequencer #(.ROW_LEN(8), .NUM_ROWS(2), .KERNEL(3), .CNT_W(16)) dut_a (
        .ONEDCONV_STATEMACHINE_Clk   (clk),
        .ONEDCONV_STATEMACHINE_Reset (rst_n),
        .bus                         (ifa)
    );

    onedconv_row_sequencer #(.ROW_LEN(4), .NUM_ROWS(3), .KERNEL(1), .CNT_W(16)) dut_b (
        .ONEDCONV_STATEMACHINE_Clk   (clk),
        .ONEDCONV_STATEMACHINE_Reset (rst_n),
        .bus                         (ifb)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {clr_n, set_en, o_en, busy, done}
    function automatic int outs_a();
        return int'({ifa.next_row_clr_n, ifa.set_en, ifa.o_en, ifa.busy, ifa.done});
    endfunction

    typedef struct {
        logic en, start, stall, abort;
        logic clr_n, set_en, o_en, busy, done;
        int   col, row;
        bit   chk_cnt;
    } vec_t;

    vec_t vecs[17];

    // Run one image on dut_a. stall_plan freezes cycles 2-4 (FILL col 1) and
    // 9-11 (RUN col 5); abort_cyc>0 raises abort in that cycle.
    task automatic image_a(input bit stall_plan, input int abort_cyc,
                           output int se, output int oe, output int dcyc, output int ndone);
        se = 0; oe = 0; dcyc = 0; ndone = 0;
        @(negedge clk); ifa.en = 1'b1; ifa.start = 1'b0; ifa.stall = 1'b0; ifa.abort = 1'b0;
        @(negedge clk); ifa.en = 1'b0; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            ifa.stall = stall_plan && ((cyc >= 2 && cyc <= 4) || (cyc >= 9 && cyc <= 11));
            ifa.abort = (cyc == abort_cyc);
            #1;
            if (ifa.set_en) se++;
            if (ifa.o_en) oe++;
            if (ifa.done) begin
                ndone++;
                if (dcyc == 0) dcyc = cyc;
            end
            if (ifa.stall) begin
                chk("stall_enables", int'({ifa.set_en, ifa.o_en}), 0);
                chk("stall_col", int'(ifa.col_idx), (cyc <= 4) ? 1 : 5);
            end
            if (abort_cyc != 0 && cyc == abort_cyc + 1)
                chk("abort_state", int'({ifa.next_row_clr_n, ifa.busy, ifa.col_idx, ifa.row_idx}), 0);
            if (dcyc != 0 && cyc == dcyc + 1)
                chk("busy_after_done", int'({ifa.busy, ifa.done}), 0);
            @(negedge clk);
        end
        ifa.stall = 1'b0;
        ifa.abort = 1'b0;
    endtask

    initial begin
        int se, oe, dcyc, ndone, mism, clrs;

        ifa.en = 1'b0; ifa.start = 1'b0; ifa.stall = 1'b0; ifa.abort = 1'b0;
        ifb.en = 1'b0; ifb.start = 1'b0; ifb.stall = 1'b0; ifb.abort = 1'b0;

        //         en st sl ab | clr se oe bsy dn | col row chk
        vecs[0]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1};  // IDLE
        vecs[1]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1};  // IDLE, arm
        vecs[2]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1};  // ARMED, start
        vecs[3]  = '{0, 0, 0, 0,  1, 1, 0, 1, 0,  0, 0, 1};  // FILL col0
        vecs[4]  = '{0, 0, 1, 0,  1, 0, 0, 1, 0,  1, 0, 1};  // FILL stalled
        vecs[5]  = '{0, 0, 0, 0,  1, 1, 0, 1, 0,  1, 0, 1};  // FILL col1 -> RUN
        vecs[6]  = '{0, 0, 0, 0,  1, 1, 1, 1, 0,  2, 0, 1};  // RUN col2
        vecs[7]  = '{0, 1, 1, 0,  1, 0, 0, 1, 0,  3, 0, 1};  // RUN stalled, start ignored
        vecs[8]  = '{0, 0, 0, 0,  1, 1, 1, 1, 0,  3, 0, 1};
        vecs[9]  = '{0, 0, 0, 0,  1, 1, 1, 1, 0,  4, 0, 1};
        vecs[10] = '{0, 0, 0, 0,  1, 1, 1, 1, 0,  5, 0, 1};
        vecs[11] = '{0, 0, 0, 0,  1, 1, 1, 1, 0,  6, 0, 1};
        vecs[12] = '{0, 0, 0, 0,  1, 1, 1, 1, 0,  7, 0, 1};  // last pixel of row 0
        vecs[13] = '{0, 0, 1, 0,  0, 0, 0, 1, 0,  0, 0, 0};  // ROW_END, stall ignored
        vecs[14] = '{0, 0, 0, 0,  1, 1, 0, 1, 0,  0, 1, 1};  // FILL row1 col0
        vecs[15] = '{0, 0, 1, 1,  1, 0, 0, 1, 0,  1, 1, 1};  // abort beats stall
        vecs[16] = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1};  // IDLE, counters cleared

        // Reset state
        #12;
        chk("reset_outs", outs_a(), 0);
        chk("reset_cnt", int'({ifa.col_idx, ifa.row_idx}), 0);
        @(negedge clk); rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            ifa.en = vecs[i].en; ifa.start = vecs[i].start;
            ifa.stall = vecs[i].stall; ifa.abort = vecs[i].abort;
            #1;
            chk($sformatf("vec%0d_outs", i), outs_a(),
                int'({vecs[i].clr_n, vecs[i].set_en, vecs[i].o_en, vecs[i].busy, vecs[i].done}));
            if (vecs[i].chk_cnt) begin
                chk($sformatf("vec%0d_col", i), int'(ifa.col_idx), vecs[i].col);
                chk($sformatf("vec%0d_row", i), int'(ifa.row_idx), vecs[i].row);
            end
        end
        ifa.en = 1'b0; ifa.start = 1'b0; ifa.stall = 1'b0; ifa.abort = 1'b0;

        // Full image, no stall
        image_a(1'b0, 0, se, oe, dcyc, ndone);
        chk("t1_set_en", se, 16);
        chk("t1_o_en", oe, 12);
        chk("t1_done_cyc", dcyc, 18);
        chk("t1_done_cnt", ndone, 1);
        chk("t1_final_row", int'(ifa.row_idx), 1);

        // Two 3-cycle stalls
        image_a(1'b1, 0, se, oe, dcyc, ndone);
        chk("t2_set_en", se, 16);
        chk("t2_o_en", oe, 12);
        chk("t2_done_cyc", dcyc, 24);

        // Abort in RUN of row 1, then a clean image
        image_a(1'b0, 13, se, oe, dcyc, ndone);
        chk("t3_set_en", se, 12);
        chk("t3_o_en", oe, 8);
        chk("t3_no_done", ndone, 0);
        image_a(1'b0, 0, se, oe, dcyc, ndone);
        chk("t3_rerun_set_en", se, 16);
        chk("t3_rerun_done_cyc", dcyc, 18);

        // Async reset mid-FILL
        @(negedge clk); ifa.en = 1'b1;
        @(negedge clk); ifa.en = 1'b0; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        #2;
        chk("t4_pre_busy", int'(ifa.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_reset_outs", outs_a(), 0);
        chk("t4_reset_cnt", int'({ifa.col_idx, ifa.row_idx}), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t4_stays_idle", outs_a(), 0);
            @(negedge clk);
        end

        // KERNEL=1 instance
        se = 0; oe = 0; dcyc = 0; mism = 0; clrs = 0;
        ifb.en = 1'b1;
        @(negedge clk); ifb.en = 1'b0; ifb.start = 1'b1;
        @(negedge clk); ifb.start = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            #1;
            if (ifb.set_en) se++;
            if (ifb.o_en) oe++;
            if (ifb.o_en != ifb.set_en) mism++;
            if (ifb.busy && !ifb.next_row_clr_n) clrs++;
            if (ifb.done && dcyc == 0) dcyc = cyc;
            @(negedge clk);
        end
        chk("t5_set_en", se, 12);
        chk("t5_o_en", oe, 12);
        chk("t5_oen_eq_seten", mism, 0);
        chk("t5_row_clears", clrs, 2);
        chk("t5_done_cyc", dcyc, 15);

        // start in IDLE is ignored; start held through DONE restarts after ARMED
        ifa.start = 1'b1;
        #1 chk("t6_idle_start0", outs_a(), 0);
        @(negedge clk);
        #1 chk("t6_idle_start1", outs_a(), 0);
        ifa.en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dcyc = 0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            #1;
            if (ifa.done && dcyc == 0) dcyc = cyc;
            if (dcyc != 0 && cyc == dcyc + 1)
                chk("t6_rearmed", outs_a(), 5'b10000);
            if (dcyc != 0 && cyc == dcyc + 2)
                chk("t6_restart", int'({ifa.busy, ifa.set_en}), 3);
            @(negedge clk);
        end
        chk("t6_done_cyc", dcyc, 18);
        ifa.en = 1'b0; ifa.start = 1'b0; ifa.abort = 1'b1;
        @(negedge clk); ifa.abort = 1'b0;
        #1 chk("t6_abort_idle", outs_a(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
